// File: rtl/lm96570_serial_target.sv
// Serial-register target for the LM96570 three-wire programming port.
// Oversamples sCLK/sWR/sLE on clk, decodes read/write frames, and serves a 32-entry register file.
module lm96570_serial_target #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              sCLK,
    input  logic              sWR,
    input  logic              sLE,
    output logic              sRD,
    input  logic [4:0]        loc_addr,
    output logic [DATA_W-1:0] loc_data,
    output logic              wr_strobe,
    output logic [4:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_err
);

    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned NREG      = 32;
    localparam int unsigned HDR_LEN   = 6;
    localparam int unsigned FRAME_LEN = HDR_LEN + DATA_W;
    localparam int unsigned CNT_W     = 6;

    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_HLAST = CNT_W'(HDR_LEN - 1);

    typedef enum logic [1:0] {IDLE, HDR, WDATA, RDATA} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_q, swr_q, sle_q;
    logic                   sclk_d, sle_d;
    logic                   sclk_s, swr_s, sle_s;
    logic                   le_fall, le_rise, ck_rise, ck_fall;

    logic [CNT_W-1:0]  bit_cnt;
    logic [4:0]        hdr_sr;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] hdr_addr;
    logic [DATA_W-1:0] data_sr;
    logic [DATA_W-1:0] rd_sr;
    logic [DATA_W-1:0] regs [NREG];

    logic cnt_clr, cnt_inc, hdr_shift, hdr_done, data_shift, commit, err, rd_shift, rd_clr;

    // sLE idles high, so its synchronizer resets high to avoid a phantom frame edge.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            sclk_q <= '0;
            swr_q  <= '0;
            sle_q  <= '1;
            sclk_d <= 1'b0;
            sle_d  <= 1'b1;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], sCLK};
            swr_q  <= {swr_q[SYNC_STAGES-2:0], sWR};
            sle_q  <= {sle_q[SYNC_STAGES-2:0], sLE};
            sclk_d <= sclk_s;
            sle_d  <= sle_s;
        end
    end

    assign sclk_s   = sclk_q[SYNC_STAGES-1];
    assign swr_s    = swr_q[SYNC_STAGES-1];
    assign sle_s    = sle_q[SYNC_STAGES-1];
    assign le_fall  = sle_d & ~sle_s;
    assign le_rise  = ~sle_d & sle_s;
    assign ck_rise  = ~sclk_d & sclk_s & ~sle_s;
    assign ck_fall  = sclk_d & ~sclk_s & ~sle_s;
    assign hdr_addr = {hdr_sr[3:0], swr_s};

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_nxt;
    end

    // sLE rise takes priority over any sCLK edge seen in the same cycle.
    always_comb begin
        state_nxt  = state;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        hdr_shift  = 1'b0;
        hdr_done   = 1'b0;
        data_shift = 1'b0;
        commit     = 1'b0;
        err        = 1'b0;
        rd_shift   = 1'b0;
        rd_clr     = 1'b0;
        case (state)
            IDLE: begin
                if (le_fall) begin
                    state_nxt = HDR;
                    cnt_clr   = 1'b1;
                end
            end
            HDR: begin
                if (le_rise) begin
                    state_nxt = IDLE;
                    err       = 1'b1;
                end else if (ck_rise) begin
                    cnt_inc   = 1'b1;
                    hdr_shift = 1'b1;
                    if (bit_cnt == CNT_HLAST) begin
                        hdr_done  = 1'b1;
                        state_nxt = hdr_sr[4] ? RDATA : WDATA;
                    end
                end
            end
            WDATA: begin
                if (le_rise) begin
                    state_nxt = IDLE;
                    commit    = (bit_cnt == CNT_FRAME);
                    err       = (bit_cnt != CNT_FRAME);
                end else if (ck_rise) begin
                    cnt_inc    = 1'b1;
                    data_shift = 1'b1;
                end
            end
            RDATA: begin
                if (le_rise) begin
                    state_nxt = IDLE;
                    rd_clr    = 1'b1;
                    err       = (bit_cnt != CNT_FRAME);
                end else begin
                    cnt_inc  = ck_rise;
                    rd_shift = ck_fall;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame datapath: bit counter, header/data shifters, read snapshot and sRD.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            bit_cnt   <= '0;
            hdr_sr    <= '0;
            addr_q    <= '0;
            data_sr   <= '0;
            rd_sr     <= '0;
            sRD       <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            if (cnt_clr)                          bit_cnt <= '0;
            else if (cnt_inc && bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + CNT_W'(1);
            if (hdr_shift) hdr_sr <= {hdr_sr[3:0], swr_s};
            if (data_shift) data_sr <= {data_sr[DATA_W-2:0], swr_s};
            if (hdr_done) begin
                addr_q <= hdr_addr;
                rd_sr  <= regs[hdr_addr];
            end else if (rd_shift) begin
                rd_sr <= {rd_sr[DATA_W-2:0], 1'b0};
            end
            if (rd_clr)        sRD <= 1'b0;
            else if (rd_shift) sRD <= rd_sr[DATA_W-1];
            wr_strobe <= commit;
            frame_err <= err;
            if (commit) begin
                wr_addr <= addr_q;
                wr_data <= data_sr;
            end
        end
    end

    // Register file and registered local read port.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
            loc_data <= '0;
        end else begin
            if (commit) regs[addr_q] <= data_sr;
            loc_data <= regs[loc_addr];
        end
    end

endmodule

// File: tb/tb_lm96570_serial_target.sv
// Bench for lm96570_serial_target: directed vector table, reset corners, and random frames
// checked against an array model of the register file.
module tb_lm96570_serial_target;

    localparam int DW  = 16;
    localparam int SS  = 2;
    localparam int PH  = SS + 3;
    localparam int GAP = SS + 2;
    localparam int FL  = 6 + DW;

    logic          clk = 1'b0;
    logic          RESET;
    logic          sCLK, sWR, sLE, sRD;
    logic [4:0]    loc_addr;
    logic [DW-1:0] loc_data;
    logic          wr_strobe;
    logic [4:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          frame_err;

    lm96570_serial_target #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
        .clk(clk), .RESET(RESET), .sCLK(sCLK), .sWR(sWR), .sLE(sLE), .sRD(sRD),
        .loc_addr(loc_addr), .loc_data(loc_data), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]    a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        bit            rw;
        logic [4:0]    a;
        logic [DW-1:0] d;
        int            nb;
        bit            exp_wr;
        bit            exp_err;
        bit            chk_rd;
        logic [DW-1:0] exp_rd;
        bit            fast;
    } vec_t;

    int            n_vec = 0;
    int            n_bad = 0;
    int            err_cnt = 0;
    bit            both_seen = 1'b0;
    wr_t           strobe_q[$];
    logic [DW-1:0] model [32];
    vec_t          tbl [12];

    // Pulse monitor: records every committed write and error pulse.
    always @(negedge clk) begin
        if (RESET === 1'b1) begin
            if (wr_strobe) strobe_q.push_back('{wr_addr, wr_data});
            if (frame_err) err_cnt++;
            if (wr_strobe && frame_err) both_seen = 1'b1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_outs_zero(input string nm);
        chk({nm, "_srd"}, 32'(sRD), 32'h0);
        chk({nm, "_loc"}, 32'(loc_data), 32'h0);
        chk({nm, "_stb"}, 32'(wr_strobe), 32'h0);
        chk({nm, "_wa"}, 32'(wr_addr), 32'h0);
        chk({nm, "_wd"}, 32'(wr_data), 32'h0);
        chk({nm, "_err"}, 32'(frame_err), 32'h0);
    endtask

    // Master side of one frame: nb bits MSB first; sRD captured before each data-bit rise.
    task automatic frame(input bit rw, input logic [4:0] a, input logic [DW-1:0] d,
                         input int nb, input bit fin, output logic [DW-1:0] rd);
        logic [FL-1:0] bits;
        bits = {rw, a, d};
        rd   = '0;
        sLE  = 1'b0;
        cyc(PH);
        for (int i = 0; i < nb; i++) begin
            if (i < FL) sWR = bits[FL-1-i];
            else        sWR = 1'b0;
            cyc(PH);
            if (i >= 6 && i < FL) rd = {rd[DW-2:0], sRD};
            sCLK = 1'b1;
            cyc(PH);
            sCLK = 1'b0;
        end
        if (fin) begin
            cyc(PH);
            sLE = 1'b1;
            sWR = 1'b0;
            cyc(GAP);
        end
    endtask

    task automatic do_vec(input vec_t v, input string nm);
        int            s0, e0;
        logic [DW-1:0] rd;
        s0 = strobe_q.size();
        e0 = err_cnt;
        frame(v.rw, v.a, v.d, v.nb, 1'b1, rd);
        chk({nm, "_nstrobe"}, 32'(strobe_q.size()), 32'(s0 + (v.exp_wr ? 1 : 0)));
        chk({nm, "_nerr"}, 32'(err_cnt), 32'(e0 + (v.exp_err ? 1 : 0)));
        chk({nm, "_srd_idle"}, 32'(sRD), 32'h0);
        if (v.exp_wr) begin
            model[v.a] = v.d;
            if (strobe_q.size() > 0) begin
                chk({nm, "_wa"}, 32'(strobe_q[$].a), 32'(v.a));
                chk({nm, "_wd"}, 32'(strobe_q[$].d), 32'(v.d));
            end
            chk({nm, "_wa_held"}, 32'(wr_addr), 32'(v.a));
            chk({nm, "_wd_held"}, 32'(wr_data), 32'(v.d));
            if (!v.fast) begin
                loc_addr = v.a;
                cyc(1);
                chk({nm, "_loc"}, 32'(loc_data), 32'(v.d));
            end
        end
        if (v.chk_rd) chk({nm, "_rdata"}, 32'(rd), 32'(v.exp_rd));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rd;
        vec_t          v;
        int            r;

        tbl[0]  = '{1'b0, 5'd5,  16'hA5C3, FL,     1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[1]  = '{1'b1, 5'd5,  16'h0000, FL,     1'b0, 1'b0, 1'b1, 16'hA5C3, 1'b0};
        tbl[2]  = '{1'b0, 5'd5,  16'h1234, FL - 1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
        tbl[3]  = '{1'b0, 5'd5,  16'h1234, FL + 1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
        tbl[4]  = '{1'b1, 5'd5,  16'h0000, FL,     1'b0, 1'b0, 1'b1, 16'hA5C3, 1'b0};
        tbl[5]  = '{1'b0, 5'd0,  16'h1111, FL,     1'b1, 1'b0, 1'b0, 16'h0000, 1'b1};
        tbl[6]  = '{1'b0, 5'd31, 16'h2222, FL,     1'b1, 1'b0, 1'b0, 16'h0000, 1'b1};
        tbl[7]  = '{1'b0, 5'd0,  16'h3333, FL,     1'b1, 1'b0, 1'b0, 16'h0000, 1'b1};
        tbl[8]  = '{1'b1, 5'd31, 16'h0000, FL,     1'b0, 1'b0, 1'b1, 16'h2222, 1'b1};
        tbl[9]  = '{1'b1, 5'd0,  16'h0000, FL,     1'b0, 1'b0, 1'b1, 16'h3333, 1'b0};
        tbl[10] = '{1'b1, 5'd5,  16'h0000, FL - 1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
        tbl[11] = '{1'b0, 5'd9,  16'hBEEF, 0,      1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};

        for (int i = 0; i < 32; i++) model[i] = '0;
        RESET = 1'b0; sCLK = 1'b0; sWR = 1'b0; sLE = 1'b1; loc_addr = '0;
        cyc(3);
        chk_outs_zero("reset");
        RESET = 1'b1;
        cyc(3);

        // Reset mid-frame: 10 bits of a write to addr 7, then RESET.
        frame(1'b0, 5'd7, 16'hFFFF, 10, 1'b0, rd);
        RESET = 1'b0;
        cyc(2);
        chk_outs_zero("midrst");
        sLE = 1'b1; sCLK = 1'b0; sWR = 1'b0;
        cyc(1);
        RESET = 1'b1;
        cyc(GAP);
        loc_addr = 5'd7;
        cyc(1);
        chk("midrst_reg7", 32'(loc_data), 32'h0);

        for (int i = 0; i < 12; i++) do_vec(tbl[i], $sformatf("tbl%0d", i));

        loc_addr = 5'd5;
        cyc(1);
        chk("reg5_kept", 32'(loc_data), 32'hA5C3);

        for (int i = 0; i < 40; i++) begin
            r        = int'($urandom_range(0, 9));
            v.rw     = 1'($urandom_range(0, 1));
            v.a      = 5'($urandom_range(0, 31));
            v.d      = DW'($urandom);
            v.nb     = (r < 7) ? FL : (r == 7) ? FL - 1 : (r == 8) ? FL + 1 : 6;
            v.exp_wr = !v.rw && (v.nb == FL);
            v.exp_err = (v.nb != FL);
            v.chk_rd = v.rw && (v.nb == FL);
            v.exp_rd = model[v.a];
            v.fast   = 1'b0;
            do_vec(v, $sformatf("rnd%0d", i));
        end

        // Reset mid-stream during a read, then every register must read back zero.
        frame(1'b1, 5'd31, 16'h0000, 12, 1'b0, rd);
        RESET = 1'b0;
        cyc(2);
        chk_outs_zero("rst2");
        sLE = 1'b1; sCLK = 1'b0; sWR = 1'b0;
        cyc(1);
        RESET = 1'b1;
        cyc(GAP);
        for (int i = 0; i < 32; i++) begin
            loc_addr = 5'(i);
            cyc(1);
            chk($sformatf("sweep%0d", i), 32'(loc_data), 32'h0);
        end

        chk("strobe_err_excl", 32'(both_seen), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
